// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between a datapath initiator and
// the data_mem_responder. The initiator holds mem_req until mem_ack.
interface data_mem_responder_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;

    modport master (
        output mem_req, mem_we, mem_adr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_adr, mem_be, mem_wdata,
        output mem_rdata, mem_ack, mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory that answers one request
// at a time after a fixed number of wait cycles (LATENCY). Byte-lane writes,
// full-word reads, addresses wrap modulo the storage depth.
// Optional build macro DMEM_ALIGN_CHECK_EN: flag and suppress accesses whose
// byte address is not word aligned (mem_err in the response cycle).
module data_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int         DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_accept;
    logic                  w_enter_resp;

    // captured request
    logic                  r_we;
    logic [31:0]           r_adr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;

    // request fields used at the response edge
    logic                  w_we;
    logic [31:0]           w_adr;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [ADDR_BITS-1:0]  w_idx;
    logic                  w_misalign;
    logic                  w_unused_adr;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;

    // State register and wait counter; reset abandons any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept only in IDLE, count down in WAIT, single RESP cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_req) begin
                    w_accept = 1'b1;
                    if (LAT4 == 4'd0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = LAT4;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture the request on acceptance so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= bus.mem_we;
            r_adr   <= bus.mem_adr;
            r_be    <= bus.mem_be;
            r_wdata <= bus.mem_wdata;
        end
    end

    // With zero latency the response edge is the capture edge, so use the live inputs
    assign w_we    = (r_state == IDLE) ? bus.mem_we    : r_we;
    assign w_adr   = (r_state == IDLE) ? bus.mem_adr   : r_adr;
    assign w_be    = (r_state == IDLE) ? bus.mem_be    : r_be;
    assign w_wdata = (r_state == IDLE) ? bus.mem_wdata : r_wdata;
    assign w_idx   = w_adr[ADDR_BITS+1:2];

    // Upper address bits alias; low two bits matter only for the alignment check
    assign w_unused_adr = ^{w_adr[31:ADDR_BITS+2], w_adr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = (w_adr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Commit enabled byte lanes on the edge entering RESP; never while in reset
    always_ff @(posedge clk) begin
        if (w_enter_resp && rst && w_we && !w_misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response data: addressed word for aligned reads, zero otherwise; held between responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
        end else if (w_enter_resp) begin
            r_rdata <= (w_we || w_misalign) ? 32'd0 : r_mem[w_idx];
        end
    end

    assign bus.mem_rdata = r_rdata;
    assign bus.mem_ack   = (r_state == RESP);

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_err;

    // Misalignment flag, raised only for the RESP cycle of the offending access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_resp && w_misalign;
        end
    end

    assign bus.mem_err = r_err;
`else
    assign bus.mem_err = 1'b0;
`endif

endmodule
